// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding, the default frame geometry and the parity-sense values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_DEF_DATA_BITS  = 8;
    localparam int UART_DEF_OVERSAMPLE = 16;

    localparam int UART_PARITY_EVEN = 0;
    localparam int UART_PARITY_ODD  = 1;

    // Two-out-of-three vote used to resolve each bit from its three mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Both flops reset to the idle-high level, so leaving reset never looks like a start edge.
// rx_fall is a registered one-cycle pulse that lines up with the cycle in which rx_sync first reads 0.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta;
    logic sync;

    // Shift rx through the metastability flop and the stable flop, and flag a high-to-low change.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            rx_fall <= 1'b0;
        end else begin
            meta    <= rx;
            sync    <= meta;
            rx_fall <= sync & ~meta;
        end
    end

    assign rx_sync = sync;

endmodule

// File: rtl/uart_rx_checked.sv
// Hardened UART receiver: 16x-style oversampling, 3-sample majority vote per bit,
// one-cycle rx_valid strobe with parity, framing and line-break flags.
// Optional parity bit enabled by defining the macro UART_RX_PARITY_EN; without it parity_err is 0.
module uart_rx_checked
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DEF_DATA_BITS,
    parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE,
    parameter int PARITY_ODD = UART_PARITY_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_SAMP0 = TW'(MID - 1);
    localparam logic [TW-1:0] T_SAMP1 = TW'(MID);
    localparam logic [TW-1:0] T_VOTE  = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

    localparam bit PAR_SENSE = (PARITY_ODD != UART_PARITY_EVEN);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    uart_rx_state_t         state;
    uart_rx_state_t         state_next;

    logic                   rx_sync;
    logic                   rx_fall;

    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [1:0]             samp;
    logic                   par_bit;

    logic                   voted;
    logic                   vote_tick;
    logic                   end_tick;
    logic                   last_bit;
    logic                   par_mismatch;

    logic                   tcnt_clr;
    logic                   bit_clr;
    logic                   bit_inc;
    logic                   shift_en;
    logic                   par_load;
    logic                   emit;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    // The third sample is the live synchronized line on the vote tick itself.
    assign voted        = majority3(samp[0], samp[1], rx_sync);
    assign vote_tick    = s_tick && (tcnt == T_VOTE);
    assign end_tick     = s_tick && (tcnt == T_LAST);
    assign last_bit     = (bit_cnt == B_LAST);
    assign par_mismatch = ((^shift_reg) ^ par_bit) != PAR_SENSE;
    assign busy         = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state datapath controls; the stop bit resolves at its vote tick so the receiver resyncs early.
    always_comb begin
        state_next = state;
        tcnt_clr   = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    tcnt_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (vote_tick && voted) begin
                    state_next = IDLE;
                end else if (end_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (vote_tick) begin
                    shift_en = 1'b1;
                end
                if (end_tick) begin
                    if (last_bit) begin
                        bit_clr    = 1'b1;
                        state_next = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (vote_tick) begin
                    par_load = 1'b1;
                end
                if (end_tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (vote_tick) begin
                    emit       = 1'b1;
                    state_next = voted ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Oversampling tick counter: restarts at the start edge and otherwise wraps once per bit period.
    always_ff @(posedge clk) begin
        if (reset || tcnt_clr) begin
            tcnt <= '0;
        end else if (s_tick) begin
            tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
        end
    end

    // Capture the first two of the three mid-bit samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp <= 2'b11;
        end else if (s_tick && (tcnt == T_SAMP0)) begin
            samp[0] <= rx_sync;
        end else if (s_tick && (tcnt == T_SAMP1)) begin
            samp[1] <= rx_sync;
        end
    end

    // Data bit position within the frame.
    always_ff @(posedge clk) begin
        if (reset || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Shift voted data bits in LSB first; the parity bit is kept separately and cleared at each new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
            end
            if (tcnt_clr) begin
                par_bit <= 1'b0;
            end else if (par_load) begin
                par_bit <= voted;
            end
        end
    end

    // Registered result: one-cycle strobe, flags only while strobing, character held between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid   <= emit;
            parity_err <= emit & PAR_EN & par_mismatch;
            frame_err  <= emit & ~voted;
            break_det  <= emit & ~voted & (shift_reg == '0) & ~par_bit;
            if (emit) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: doc/uart_rx_checked.md
# uart_rx_checked

Hardened UART receiver for the UART subsystem. Samples the asynchronous `rx` line with the shared 16x oversampling tick from the baud generator and votes 3 samples per bit. Delivers each received character as a one-cycle `rx_valid` strobe with data and error flags. Its output pair `rx_valid`/`rx_data` connects directly to the RX FIFO write port; the error flags go to status logic.

## Interface
- `DATA_BITS`, 8: data bits per frame (5..9), sent LSB first.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; even, ≥ 8.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd. Only meaningful when `UART_RX_PARITY_EN` is defined.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `s_tick`  in  1  oversampling tick, one `clk` wide.
- `rx_valid`  out  1  one-cycle strobe: a frame has completed.
- `rx_data`  out  DATA_BITS  last received character; held between strobes.
- `parity_err`  out  1  qualified by `rx_valid`: parity mismatch.
- `frame_err`  out  1  qualified by `rx_valid`: stop bit sampled low.
- `break_det`  out  1  qualified by `rx_valid`: all-zero frame including the stop bit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. Start detection uses a falling edge of the synchronized line.
- Tick counter `tcnt` has width $clog2(OVERSAMPLE) and advances only on `s_tick`. It wraps at OVERSAMPLE-1 and then advances the bit position.
- Each bit is sampled at `tcnt` = M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples.
- States:
  - IDLE: on a falling edge, clear `tcnt` and go to START.
  - START: if the start-bit majority is 1, the start was false; return to IDLE with no output. Otherwise, at the bit end, go to DATA.
  - DATA: shift the voted bit in LSB first. The bit counter has width $clog2(DATA_BITS). After DATA_BITS bits, go to PARITY (macro defined) or STOP.
  - PARITY: compare the voted bit with the computed parity.
  - STOP: resolve the vote at `tcnt` = M+1. Emit the result. If the stop bit is 1, go to IDLE; if it is 0, go to WAIT_IDLE. Do not wait out the rest of the stop bit; this allows early resync.
  - WAIT_IDLE: stay until the synchronized `rx` = 1, then go to IDLE. Blocks false restarts during a line break.
- On emit:
  - `rx_data` loads the shift register.
  - `frame_err` = !stop.
  - `break_det` = frame_err && data == 0 && (parity bit == 0 when enabled).
  - When `break_det` = 1, `frame_err` is also 1.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0. Internal state is IDLE and the synchronizer flops are 1.
- Latency: `rx_valid` is registered and asserts in the `clk` cycle after the `s_tick` that completes the stop-bit vote.
- Error flags are valid only while `rx_valid`=1 and are 0 otherwise.
- There is no backpressure. The consumer must accept every strobe.
- Falling edges seen outside IDLE are ignored.
- Reset asserted mid-frame: the block returns to IDLE within one cycle, the partial frame is discarded and no strobe is produced.
- If `s_tick` stalls (held low), the frame freezes; no timeout.

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state is inserted after DATA. The frame is DATA_BITS+1 bits plus stop. `parity_err` reports a mismatch against the `PARITY_ODD` sense.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state. `parity_err` is tied to 0. Frame format is 8N1 (for DATA_BITS=8).

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - constants `UART_DEF_DATA_BITS`=8 and `UART_DEF_OVERSAMPLE`=16;
  - parity-sense constants.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer with reset-to-1 and a registered falling-edge pulse output.

## Test plan
All scenarios use OVERSAMPLE=16, DATA_BITS=8 and `s_tick` every 4 clocks.
- Clean 8N1 frame 0xA5 → exactly one `rx_valid`, `rx_data`=0xA5, all error flags 0, `busy` low afterwards.
- `rx` low for 4 ticks then high (glitch) → no `rx_valid`; `busy` returns to 0 after the start-bit vote.
- Frame 0x3C with the stop bit driven 0, then `rx` held high → `rx_valid` with `frame_err`=1, `break_det`=0, `rx_data`=0x3C. A following 0x55 frame is received cleanly.
- `rx` held low for 20 bit times → exactly one `rx_valid` with `break_det`=1, `frame_err`=1, `rx_data`=0x00, then no strobes until `rx` goes high. The next frame 0x81 is received correctly.
- Frame 0xFF with a single low sample at `tcnt`=8 of bit 3 → majority vote keeps the bit, `rx_data`=0xFF. Separately, `reset` asserted at data bit 4 → no strobe and all outputs 0.
- Macro defined, even parity: 0x07 with parity bit 1 → `parity_err`=0. The same frame with parity bit 0 → `parity_err`=1, `rx_data`=0x07.
